// File: rtl/branch_seq_pkg.sv
// Shared definitions for the ID-stage branch sequencer: comparator opcodes,
// sequencer state encodings and the branch-target helper.
package branch_seq_pkg;

    localparam logic [2:0] CMP_BEQ    = 3'd0;
    localparam logic [2:0] CMP_BNE    = 3'd1;
    localparam logic [2:0] CMP_BLTZAL = 3'd2;

    localparam logic [0:0] BR_S_IDLE = 1'b0;
    localparam logic [0:0] BR_S_WAIT = 1'b1;

    localparam int BR_MAX_WAIT = 3;

    // PC-relative target: pc + 4 + (sext(offset) << 2), wrapping at 2^32
    function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] offset);
        return pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/branch_seq_cmp.sv
// Branch condition comparator; unknown opcodes never jump.
module branch_seq_cmp
    import branch_seq_pkg::*;
(
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [2:0]  cmpop,
    output logic        jump
);

    // Evaluate the branch condition selected by cmpop
    always_comb begin
        jump = 1'b0;
        case (cmpop)
            CMP_BEQ:    jump = (rs_val == rt_val);
            CMP_BNE:    jump = (rs_val != rt_val);
            CMP_BLTZAL: jump = rs_val[31];
            default:    jump = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_seq.sv
// ID-stage branch sequencer: stalls on unready operands, resolves branches in
// the same cycle, drives NPC redirect / link write and keeps debug statistics.
module branch_seq
    import branch_seq_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = BR_MAX_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic [2:0]       id_cmpop,
    input  logic [31:0]      id_pc,
    input  logic [15:0]      id_offset,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    output logic             stall_req,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             link_we,
    output logic [31:0]      link_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             hazard_err
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]        state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              jump_s;
    logic              branch_s;
    logic              rdy_s;
    logic              resolve_s;
    logic              stall_s;
    logic              show_s;

    branch_seq_cmp u_cmp (
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cmpop  (id_cmpop),
        .jump   (jump_s)
    );

    // Resolve/stall decode; a flushed WAIT neither stalls nor resolves
    always_comb begin
        branch_s    = id_valid & id_branch;
        rdy_s       = rs_ready & (rt_ready | (id_cmpop == CMP_BLTZAL));
        resolve_s   = ~freeze & branch_s & rdy_s;
        stall_s     = ~freeze & branch_s & ~rdy_s;
        show_s      = (state_r == BR_S_WAIT) | id_branch;
        stall_req   = stall_s;
        redirect    = resolve_s & jump_s;
        link_we     = resolve_s & (id_cmpop == CMP_BLTZAL);
        if (show_s) begin
            redirect_pc = br_target(id_pc, id_offset);
            link_pc     = id_pc + 32'd8;
        end else begin
            redirect_pc = 32'd0;
            link_pc     = 32'd0;
        end
    end

    // Sequencer state, wait timer, sticky timeout flag and saturating counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= BR_S_IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
            hazard_err <= 1'b0;
            br_cnt     <= {CNT_W{1'b0}};
            taken_cnt  <= {CNT_W{1'b0}};
            stall_cnt  <= {CNT_W{1'b0}};
        end else if (!freeze) begin
            case (state_r)
                BR_S_IDLE: begin
                    if (stall_s) begin
                        state_r    <= BR_S_WAIT;
                        wait_cnt_r <= WAIT_ONE;
                    end
                end
                BR_S_WAIT: begin
                    if (!branch_s || rdy_s) begin
                        state_r    <= BR_S_IDLE;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        if (wait_cnt_r == WAIT_MAX) begin
                            hazard_err <= 1'b1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                        end
                    end
                end
                default: begin
                    state_r    <= BR_S_IDLE;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
            endcase
            if (resolve_s && br_cnt != CNT_MAX) begin
                br_cnt <= br_cnt + CNT_ONE;
            end
            if (resolve_s && jump_s && taken_cnt != CNT_MAX) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
            if (stall_s && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule
